sequence_lut_reader: RTL and testbench

SEQUENCE_LUT_READER -- requirements
Module: sequence_lut_reader

---
 rtl/sequence_lut_reader.sv | 172 +++++++++++++++++
 tb/tb_sequence_lut_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_lut_reader.sv
// sequence_lut_reader: plays a BRAM-resident look-up table one entry per step of
// an external step counter, for a programmable number of laps. Each step issues
// one BRAM read, waits out the BRAM pipeline and presents the entry on seq_data.
module sequence_lut_reader #(
    parameter int DATA_WIDTH   = 64,
    parameter int BRAM_LATENCY = 2    // legal range 1..7
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic [31:0]           step_counter,
    input  logic [15:0]           num_steps,
    input  logic [15:0]           num_laps,
    output logic                  bram_en,
    output logic [15:0]           bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_rdata,
    output logic [DATA_WIDTH-1:0] seq_data,
    output logic                  seq_update,
    output logic                  seq_active,
    output logic                  seq_done,
    output logic                  lag_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_UPDATE,
        S_HOLD,
        S_DONE
    } state_t;

    // Last value of the WAIT counter; WAIT lasts BRAM_LATENCY-1 cycles and is
    // skipped entirely for a single-cycle BRAM.
    localparam logic [2:0] WAIT_LAST = (BRAM_LATENCY > 1) ? 3'(BRAM_LATENCY - 2) : 3'd0;

    state_t      state;
    state_t      state_next;

    logic [31:0] processed_step;
    logic [15:0] addr;
    logic [15:0] lap;
    logic [15:0] steps_q;
    logic [15:0] laps_q;
    logic [2:0]  wait_cnt;

    // Step bookkeeping shared by the next-state and datapath logic.
    logic [31:0] diff;
    logic [15:0] addr_inc;
    logic [15:0] lap_inc;
    logic        lap_wrap;
    logic        laps_done;
    logic        wait_last;

    // Modulo-2^32 subtraction makes the 0xFFFFFFFF -> 0 counter wrap a plain step of 1.
    assign diff      = step_counter - processed_step;
    assign addr_inc  = addr + 16'd1;
    assign lap_inc   = lap + 16'd1;
    assign lap_wrap  = (addr_inc == steps_q);
    assign laps_done = lap_wrap && (laps_q != 16'd0) && (lap_inc == laps_q);
    assign wait_last = (wait_cnt == WAIT_LAST);

    // State register.
    always_ff @(posedge clk or negedge aresetn) begin
        // NOTE: sequential state is always assigned with <= so every flop samples
        // pre-edge values regardless of statement order.
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; dropping enable overrides every state.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned
        // (which would infer a latch).
        state_next = state;
        if (!enable) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (num_steps != 16'd0) state_next = S_FETCH;
                S_FETCH:  state_next = (BRAM_LATENCY == 1) ? S_UPDATE : S_WAIT;
                S_WAIT:   if (wait_last) state_next = S_UPDATE;
                S_UPDATE: state_next = S_HOLD;
                S_HOLD:   if (diff != 32'd0) state_next = laps_done ? S_DONE : S_FETCH;
                S_DONE:   state_next = S_DONE;
                default:  state_next = S_IDLE;
            endcase
        end
    end

    // Datapath registers: step tracking, LUT address, lap count, output entry.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            processed_step <= 32'd0;
            addr           <= 16'd0;
            lap            <= 16'd0;
            steps_q        <= 16'd0;
            laps_q         <= 16'd0;
            wait_cnt       <= 3'd0;
            seq_data       <= '0;
            lag_error      <= 1'b0;
        end else if (!enable) begin
            // Leaving for IDLE: blank the output; any read in flight is simply
            // never captured.
            seq_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (num_steps != 16'd0) begin
                        steps_q        <= num_steps;
                        laps_q         <= num_laps;
                        processed_step <= step_counter;
                        addr           <= 16'd0;
                        lap            <= 16'd0;
                        lag_error      <= 1'b0;
                    end
                end
                S_FETCH: wait_cnt <= 3'd0;
                S_WAIT:  wait_cnt <= wait_cnt + 3'd1;
                S_UPDATE: seq_data <= bram_rdata;
                S_HOLD: begin
                    if (diff != 32'd0) begin
                        // Advance exactly one entry per visit; a backlog is
                        // drained one step at a time and flagged.
                        processed_step <= processed_step + 32'd1;
                        if (diff > 32'd1) begin
                            lag_error <= 1'b1;
                        end
                        if (lap_wrap) begin
                            addr <= 16'd0;
                            lap  <= lap_inc;
                            if (laps_done) begin
                                seq_data <= '0;
                            end
                        end else begin
                            addr <= addr_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bram_addr = addr;

    // Moore outputs decoded from the current state.
    always_comb begin
        bram_en    = 1'b0;
        seq_update = 1'b0;
        seq_active = 1'b0;
        seq_done   = 1'b0;
        case (state)
            S_FETCH: begin
                bram_en    = 1'b1;
                seq_active = 1'b1;
            end
            S_WAIT:  seq_active = 1'b1;
            S_UPDATE: begin
                seq_update = 1'b1;
                seq_active = 1'b1;
            end
            S_HOLD:  seq_active = 1'b1;
            S_DONE:  seq_done   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sequence_lut_reader.sv
// Directed bench for sequence_lut_reader with a two-stage BRAM model and a
// scoreboard of expected fetch addresses and LUT entries.
module tb_sequence_lut_reader;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic [31:0] step_counter;
    logic [15:0] num_steps;
    logic [15:0] num_laps;
    logic        bram_en;
    logic [15:0] bram_addr;
    logic [63:0] bram_rdata = 64'd0;
    logic [63:0] seq_data;
    logic        seq_update;
    logic        seq_active;
    logic        seq_done;
    logic        lag_error;

    int checks      = 0;
    int failures    = 0;
    int fetch_count = 0;
    int upd_count   = 0;
    logic upd_seen  = 1'b0;

    logic [15:0] addr_q[$];
    logic [63:0] data_q[$];
    logic [63:0] lut[0:15];
    logic [63:0] pipe1 = 64'd0;

    always #5 clk = ~clk;

    sequence_lut_reader #(.DATA_WIDTH(64), .BRAM_LATENCY(2)) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .enable       (enable),
        .step_counter (step_counter),
        .num_steps    (num_steps),
        .num_laps     (num_laps),
        .bram_en      (bram_en),
        .bram_addr    (bram_addr),
        .bram_rdata   (bram_rdata),
        .seq_data     (seq_data),
        .seq_update   (seq_update),
        .seq_active   (seq_active),
        .seq_done     (seq_done),
        .lag_error    (lag_error)
    );

    initial begin
        for (int i = 0; i < 16; i++) lut[i] = 64'(i) + 64'h10;
    end

    // BRAM model: data appears two cycles after the bram_en cycle.
    always @(posedge clk) begin
        pipe1      <= bram_en ? lut[bram_addr[3:0]] : 64'hDEAD_BEEF;
        bram_rdata <= pipe1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_step(input logic [15:0] a);
        addr_q.push_back(a);
        data_q.push_back(64'(a) + 64'h10);
    endtask

    task automatic flush(input string tag);
        check({tag, "_addr_left"}, 64'(addr_q.size()), 64'd0);
        check({tag, "_data_left"}, 64'(data_q.size()), 64'd0);
        addr_q.delete();
        data_q.delete();
    endtask

    // Scoreboard monitor: every fetch and every presented entry is matched
    // against the next expectation.
    always @(negedge clk) begin
        if (!aresetn) begin
            upd_seen <= 1'b0;
        end else begin
            if (bram_en) begin
                fetch_count <= fetch_count + 1;
                check("fetch_expected", 64'(addr_q.size() != 0), 64'd1);
                if (addr_q.size() != 0) check("fetch_addr", 64'(bram_addr), 64'(addr_q.pop_front()));
            end
            if (upd_seen) begin
                upd_count <= upd_count + 1;
                check("update_expected", 64'(data_q.size() != 0), 64'd1);
                if (data_q.size() != 0) check("seq_data", seq_data, data_q.pop_front());
            end
            upd_seen <= seq_update;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc0;
        int uc0;
        int n;
        aresetn      = 1'b0;
        enable       = 1'b0;
        step_counter = 32'd0;
        num_steps    = 16'd0;
        num_laps     = 16'd0;
        #12;
        check("rst_flags", 64'({bram_en, seq_update, seq_active, seq_done, lag_error}), 64'd0);
        check("rst_addr", 64'(bram_addr), 64'd0);
        check("rst_data", seq_data, 64'd0);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        tick(2);

        // Single step latency, infinite laps.
        num_steps = 16'd4;
        num_laps  = 16'd0;
        expect_step(16'd0);
        enable = 1'b1;
        tick(10);
        check("hold_first_data", seq_data, 64'h10);
        check("hold_flags", 64'({seq_active, seq_done, lag_error}), 64'b100);
        step_counter = 32'd1;
        expect_step(16'd1);
        tick(1);
        check("lat_fetch", 64'({bram_en, bram_addr}), 64'({1'b1, 16'd1}));
        tick(2);
        check("lat_not_early", seq_data, 64'h10);
        tick(1);
        check("lat_exact", seq_data, 64'h11);
        tick(5);
        flush("t_latency");

        // Disable clears; num_steps=0 never starts.
        enable = 1'b0;
        tick(1);
        check("disable_flags", 64'({seq_active, seq_done, bram_en}), 64'd0);
        check("disable_data", seq_data, 64'd0);
        num_steps = 16'd0;
        enable    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("zero_steps_idle", 64'({bram_en, seq_active}), 64'd0);
        end
        enable = 1'b0;
        tick(1);

        // Two laps of three entries, then DONE.
        num_steps    = 16'd3;
        num_laps     = 16'd2;
        step_counter = 32'd100;
        fc0          = fetch_count;
        expect_step(16'd0);
        enable = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(10);
            step_counter = step_counter + 32'd1;
            if (k < 6) expect_step(16'(k % 3));
        end
        tick(10);
        check("done_flags", 64'({seq_done, seq_active}), 64'b10);
        check("done_data", seq_data, 64'd0);
        for (int i = 0; i < 10; i++) begin
            step_counter = step_counter + 32'd1;
            tick(2);
        end
        check("done_fetch_total", 64'(fetch_count - fc0), 64'd6);
        check("done_still", 64'(seq_done), 64'd1);
        enable = 1'b0;
        tick(1);
        check("done_exit", 64'(seq_done), 64'd0);
        flush("t_laps");

        // Jump of three: lag flagged, no entry skipped, lag cleared on restart.
        num_steps    = 16'd8;
        num_laps     = 16'd0;
        step_counter = 32'd0;
        expect_step(16'd0);
        enable = 1'b1;
        tick(10);
        check("lag_before", 64'(lag_error), 64'd0);
        uc0 = upd_count;
        step_counter = 32'd3;
        expect_step(16'd1);
        expect_step(16'd2);
        expect_step(16'd3);
        tick(30);
        check("lag_set", 64'(lag_error), 64'd1);
        check("lag_updates", 64'(upd_count - uc0), 64'd3);
        check("lag_last_data", seq_data, 64'h13);
        enable = 1'b0;
        tick(1);
        check("lag_sticky_idle", 64'(lag_error), 64'd1);
        expect_step(16'd0);
        enable = 1'b1;
        tick(1);
        check("lag_clear_start", 64'(lag_error), 64'd0);
        tick(8);
        flush("t_lag");

        // Step counter wrap is a normal single step.
        enable = 1'b0;
        tick(1);
        step_counter = 32'hFFFF_FFFF;
        expect_step(16'd0);
        enable = 1'b1;
        tick(10);
        step_counter = 32'd0;
        expect_step(16'd1);
        tick(10);
        check("wrap_data", seq_data, 64'h11);
        check("wrap_lag", 64'(lag_error), 64'd0);
        flush("t_wrap");

        // Reset during WAIT, then restart from address 0.
        step_counter = 32'd1;
        expect_step(16'd2);
        tick(2);
        aresetn = 1'b0;
        #1;
        check("wait_rst_flags", 64'({bram_en, seq_update, seq_active, seq_done, lag_error}), 64'd0);
        check("wait_rst_addr", 64'(bram_addr), 64'd0);
        check("wait_rst_data", seq_data, 64'd0);
        data_q.delete();
        tick(2);
        aresetn = 1'b1;
        expect_step(16'd0);
        n = 0;
        while (!bram_en && n < 10) begin
            tick(1);
            n++;
        end
        check("rst_first_fetch_seen", 64'(bram_en), 64'd1);
        check("rst_first_addr", 64'(bram_addr), 64'd0);
        tick(10);
        check("rst_restart_data", seq_data, 64'h10);
        flush("t_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
